// File: rtl/pow2_accum.sv
// Purpose : sums count_p consecutive input words into one batch result, flagging carry-out.
// Latency : v_o rises the cycle after the count_p-th accept; one bubble cycle between batches.
// Backpr. : ready_o drops while a finished sum waits for yumi_i; upstream must hold data_i.
//
// Optional feature macro: POW2_ACCUM_SATURATE_EN
//   defined   -> on carry-out the sum clamps to all-ones for the rest of the batch
//   undefined -> the sum wraps modulo 2^width_p
//   overflow_o is set on carry-out in both builds and stays set until the batch is taken.
//
// Ports:
//   clk_i       single clock, all state updates on the rising edge
//   reset_i     asynchronous, active-high reset
//   data_i      operand word (width_p bits)
//   v_i         data_i valid
//   ready_o     block can accept data_i this cycle (low while reset_i is high)
//   sum_o       running partial sum in eACCUM, final batch sum in eDONE
//   overflow_o  batch sum exceeded 2^width_p-1 (sticky for the batch)
//   v_o         sum_o / overflow_o valid (eDONE)
//   yumi_i      consumer takes sum_o this cycle; ignored outside eDONE
//
// Parameters:
//   width_p     data and sum width in bits
//   count_p     words per batch, legal range 1..255 (held in an 8-bit counter)

module pow2_accum #(
    parameter int width_p = 32,
    parameter int count_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] sum_o,
    output logic               overflow_o,
    output logic               v_o,
    input  logic               yumi_i
);

    typedef enum logic {
        eACCUM = 1'b0,
        eDONE  = 1'b1
    } state_e;

    localparam logic [7:0] count_lp = 8'(count_p);

    state_e             state_q, state_d;
    logic [width_p-1:0] sum_q,   sum_d;
    logic [7:0]         cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;

    logic               accept;
    logic [width_p:0]   sum_ext;
    logic               carry;
    logic [width_p-1:0] sum_acc;
    logic [7:0]         cnt_inc;

    // ready_o is forced low during reset so nothing is handshaken while state is being cleared.
    assign ready_o    = (state_q == eACCUM) && !reset_i;
    assign v_o        = (state_q == eDONE);
    assign sum_o      = sum_q;
    assign overflow_o = ovf_q;

    assign accept  = v_i && ready_o;
    assign cnt_inc = cnt_q + 8'd1;

    // One extra bit catches the carry-out of the width_p-bit add.
    assign sum_ext = {1'b0, sum_q} + {1'b0, data_i};
    assign carry   = sum_ext[width_p];

`ifdef POW2_ACCUM_SATURATE_EN
    // Once the batch has overflowed the sum is pinned at all-ones, even if a
    // later add of zero would not itself carry.
    assign sum_acc = (carry || ovf_q) ? {width_p{1'b1}} : sum_ext[width_p-1:0];
`else
    assign sum_acc = sum_ext[width_p-1:0];
`endif

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            eACCUM: begin
                if (accept) begin
                    sum_d = sum_acc;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q || carry;
                    // The accept that completes the batch registers the final
                    // sum and enters eDONE on the same edge.
                    if (cnt_inc == count_lp) begin
                        state_d = eDONE;
                    end
                end
            end
            eDONE: begin
                // Result is held until the consumer takes it.
                if (yumi_i) begin
                    state_d = eACCUM;
                    sum_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = eACCUM;
                sum_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eACCUM;
            sum_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pow2_accum.sv
// Purpose : directed self-checking bench for pow2_accum (count_p=4 and count_p=1 instances).
// Latency : results sampled 1ns after the rising edge that produced them.
// Backpr. : upstream valid is held across ready_o=0 and must not be consumed.

module tb_pow2_accum;

    localparam int W = 32;

    logic         clk;
    logic         rst;

    logic [W-1:0] data;
    logic         v_in;
    logic         rdy;
    logic [W-1:0] sum;
    logic         ovf;
    logic         v_out;
    logic         yumi;

    logic [W-1:0] data1;
    logic         v_in1;
    logic         rdy1;
    logic [W-1:0] sum1;
    logic         ovf1;
    logic         v_out1;
    logic         yumi1;

    int checks;
    int errors;

    pow2_accum #(.width_p(W), .count_p(4)) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .data_i     (data),
        .v_i        (v_in),
        .ready_o    (rdy),
        .sum_o      (sum),
        .overflow_o (ovf),
        .v_o        (v_out),
        .yumi_i     (yumi)
    );

    pow2_accum #(.width_p(W), .count_p(1)) dut1 (
        .clk_i      (clk),
        .reset_i    (rst),
        .data_i     (data1),
        .v_i        (v_in1),
        .ready_o    (rdy1),
        .sum_o      (sum1),
        .overflow_o (ovf1),
        .v_o        (v_out1),
        .yumi_i     (yumi1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        v_in = 1'b1;
        data = w;
        tick();
        v_in = 1'b0;
    endtask

    task automatic pop();
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
    endtask

    logic [W-1:0] exp_ovf_sum;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        data   = '0;
        v_in   = 1'b0;
        yumi   = 1'b0;
        data1  = '0;
        v_in1  = 1'b0;
        yumi1  = 1'b0;
`ifdef POW2_ACCUM_SATURATE_EN
        exp_ovf_sum = 32'hFFFF_FFFF;
`else
        exp_ovf_sum = 32'h0000_0002;
`endif

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_ready_low", rdy, 0);
        check_val("rst_v_o", v_out, 0);
        check_val("rst_sum", sum, 0);
        check_val("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();
        check_val("post_rst_ready", rdy, 1);
        check_val("post_rst_ready1", rdy1, 1);

        // ---------------- batch 1,2,4,8 from exponents 0..3 ----------------
        for (int e = 0; e < 3; e++) send(W'(1) << e);
        check_val("b1_partial_sum", sum, 7);
        check_val("b1_v_o_before_last", v_out, 0);
        check_val("b1_ready_before_last", rdy, 1);
        send(W'(1) << 3);
        check_val("b1_v_o", v_out, 1);
        check_val("b1_sum", sum, 15);
        check_val("b1_ovf", ovf, 0);
        check_val("b1_ready", rdy, 0);

        // Hold 5 cycles in eDONE with upstream offering a word that must not be taken.
        v_in = 1'b1;
        data = 32'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("hold_sum", sum, 15);
            check_val("hold_v_o", v_out, 1);
        end
        v_in = 1'b0;
        pop();
        check_val("pop_v_o", v_out, 0);
        check_val("pop_ready", rdy, 1);
        check_val("pop_sum_clear", sum, 0);

        // ---------------- batch 16 x4 ----------------
        for (int i = 0; i < 4; i++) send(32'd16);
        check_val("b2_sum", sum, 64);
        check_val("b2_v_o", v_out, 1);
        pop();

        // ---------------- yumi in eACCUM is ignored ----------------
        send(32'd5);
        pop();
        check_val("yumi_ign_sum", sum, 5);
        check_val("yumi_ign_v_o", v_out, 0);
        check_val("yumi_ign_ready", rdy, 1);
        for (int i = 0; i < 3; i++) send(32'd5);
        check_val("yumi_ign_final", sum, 20);
        check_val("yumi_ign_final_v", v_out, 1);
        pop();

        // ---------------- overflow ----------------
        send(32'h8000_0000);
        check_val("ovf_first_clear", ovf, 0);
        send(32'h8000_0000);
        check_val("ovf_set", ovf, 1);
        send(32'd1);
        send(32'd1);
        check_val("ovf_sticky", ovf, 1);
        check_val("ovf_sum", sum, {32'h0, exp_ovf_sum});
        check_val("ovf_v_o", v_out, 1);
        pop();
        check_val("ovf_cleared", ovf, 0);

        // ---------------- reset mid-batch ----------------
        send(32'd4);
        send(32'd4);
        rst = 1'b1;
        #1;
        check_val("midrst_sum", sum, 0);
        check_val("midrst_v_o", v_out, 0);
        check_val("midrst_ready", rdy, 0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) send(32'd1);
        check_val("midrst_no_v_o", v_out, 0);
        send(32'd1);
        check_val("midrst_sum4", sum, 4);
        check_val("midrst_v_o4", v_out, 1);

        // ---------------- reset in eDONE discards pending sum ----------------
        rst = 1'b1;
        #1;
        check_val("donerst_v_o", v_out, 0);
        check_val("donerst_sum", sum, 0);
        tick();
        rst = 1'b0;
        tick();
        check_val("donerst_ready", rdy, 1);

        // ---------------- count_p=1, v_i held high ----------------
        v_in1 = 1'b1;
        data1 = 32'd8;
        for (int b = 0; b < 3; b++) begin
            tick();
            check_val("c1_v_o", v_out1, 1);
            check_val("c1_sum", sum1, 8);
            check_val("c1_ready", rdy1, 0);
            yumi1 = 1'b1;
            tick();
            yumi1 = 1'b0;
            check_val("c1_pop_v_o", v_out1, 0);
            check_val("c1_pop_ready", rdy1, 1);
            check_val("c1_pop_sum", sum1, 0);
        end
        v_in1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
